// File: rtl/axis_lpc_decoder.sv
// Order-4 LPC synthesis decoder: one 81-bit coded AXI-Stream frame in, eight PCM samples out.
// A single serial MAC evaluates the predictor, one coefficient per cycle.
module axis_lpc_decoder #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 12,
    parameter int RES_SHIFT = 8,
    parameter int COEF_FRAC = 10
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     S_TVALID,
    output logic                     S_TREADY,
    input  logic [4*COEF_W+8*4:0]    S_TDATA,
    input  logic                     S_TLAST,
    output logic                     M_TVALID,
    input  logic                     M_TREADY,
    output logic signed [DATA_W-1:0] M_TDATA,
    output logic                     M_TLAST
);
    localparam int RES_W   = 4;
    localparam int NSAMP   = 8;
    localparam int ORDER   = 4;
    localparam int FRAME_W = ORDER*COEF_W + NSAMP*RES_W + 1;
    localparam int PROD_W  = COEF_W + DATA_W;
    localparam int ACC_W   = 32;

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - 1;

    typedef enum logic [1:0] {IDLE, MAC, RESULT, OUT} state_t;

    function automatic logic signed [DATA_W-1:0] sat_pcm(input logic signed [ACC_W-1:0] v);
        if (v > Y_MAX) return Y_MAX[DATA_W-1:0];
        if (v < Y_MIN) return Y_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] synth_sum(input logic signed [ACC_W-1:0] acc,
                                                          input logic signed [RES_W-1:0] e);
        logic signed [ACC_W-1:0] pred;
        logic signed [ACC_W-1:0] res;
        pred = acc >>> COEF_FRAC;
        res  = $signed({{(ACC_W-RES_W){e[RES_W-1]}}, e});
        res  = res <<< RES_SHIFT;
        return pred + res;
    endfunction

    state_t                     state_q, state_d;
    logic                       s_tready_q, s_tready_d;
    logic                       m_tvalid_q, m_tvalid_d;
    logic signed [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic                       m_tlast_q, m_tlast_d;
    logic                       tlast_q, tlast_d;
    logic [2:0]                 idx_q, idx_d;
    logic [1:0]                 k_q, k_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_W-1:0]   hist_q [ORDER];
    logic signed [DATA_W-1:0]   hist_d [ORDER];
    // RST_HIST is consumed at accept time, so only the coefficient and residual fields are kept.
    logic [FRAME_W-1:1]         frame_q, frame_d;

    logic signed [COEF_W-1:0]   coef_arr [ORDER];
    logic signed [RES_W-1:0]    res_arr [NSAMP];
    logic signed [PROD_W-1:0]   prod;

    always_comb begin
        for (int k = 0; k < ORDER; k++) begin
            coef_arr[k] = $signed(frame_q[FRAME_W-1-COEF_W*k -: COEF_W]);
        end
        for (int n = 0; n < NSAMP; n++) begin
            res_arr[n] = $signed(frame_q[NSAMP*RES_W-RES_W*n -: RES_W]);
        end
    end

    assign prod = coef_arr[k_q] * hist_q[k_q];

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            tlast_q    <= 1'b0;
            idx_q      <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            for (int k = 0; k < ORDER; k++) hist_q[k] <= '0;
        end else begin
            state_q    <= state_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            tlast_q    <= tlast_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            hist_q     <= hist_d;
        end
    end

    always_ff @(posedge ACLK) begin
        frame_q <= frame_d;
    end

    always_comb begin
        state_d    = state_q;
        s_tready_d = s_tready_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        tlast_d    = tlast_q;
        idx_d      = idx_q;
        k_d        = k_q;
        acc_d      = acc_q;
        hist_d     = hist_q;
        frame_d    = frame_q;

        case (state_q)
            IDLE: begin
                // Ready is raised one cycle after reset release or frame completion.
                if (!s_tready_q) begin
                    s_tready_d = 1'b1;
                end else if (S_TVALID) begin
                    s_tready_d = 1'b0;
                    frame_d    = S_TDATA[FRAME_W-1:1];
                    tlast_d    = S_TLAST;
                    idx_d      = '0;
                    k_d        = '0;
                    acc_d      = '0;
                    if (S_TDATA[0]) begin
                        for (int k = 0; k < ORDER; k++) hist_d[k] = '0;
                    end
                    state_d    = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
                k_d   = k_q + 2'd1;
                if (k_q == 2'd3) state_d = RESULT;
            end
            RESULT: begin
                m_tdata_d  = sat_pcm(synth_sum(acc_q, res_arr[idx_q]));
                m_tvalid_d = 1'b1;
                m_tlast_d  = (idx_q == 3'd7) && tlast_q;
                state_d    = OUT;
            end
            OUT: begin
                if (M_TREADY) begin
                    m_tvalid_d = 1'b0;
                    m_tlast_d  = 1'b0;
                    hist_d[3]  = hist_q[2];
                    hist_d[2]  = hist_q[1];
                    hist_d[1]  = hist_q[0];
                    hist_d[0]  = m_tdata_q;
                    if (idx_q == 3'd7) begin
                        if (tlast_q) begin
                            for (int k = 0; k < ORDER; k++) hist_d[k] = '0;
                        end
                        s_tready_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        k_d     = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign S_TREADY = s_tready_q;
    assign M_TVALID = m_tvalid_q;
    assign M_TDATA  = m_tdata_q;
    assign M_TLAST  = m_tlast_q;

endmodule

// File: tb/tb_axis_lpc_decoder.sv
// Directed bench for axis_lpc_decoder: a sample-level reference model of the synthesis
// recurrence checked every output cycle, plus literal spot values for key frames.
module tb_axis_lpc_decoder;
    logic               ACLK = 1'b0;
    logic               ARESET;
    logic               S_TVALID;
    logic               S_TREADY;
    logic [80:0]        S_TDATA;
    logic               S_TLAST;
    logic               M_TVALID;
    logic               M_TREADY;
    logic signed [15:0] M_TDATA;
    logic               M_TLAST;

    axis_lpc_decoder dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .S_TVALID (S_TVALID),
        .S_TREADY (S_TREADY),
        .S_TDATA  (S_TDATA),
        .S_TLAST  (S_TLAST),
        .M_TVALID (M_TVALID),
        .M_TREADY (M_TREADY),
        .M_TDATA  (M_TDATA),
        .M_TLAST  (M_TLAST)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int   data;
        logic last;
    } samp_t;

    samp_t exp_q[$];
    int    got[$];
    int    checks = 0;
    int    errors = 0;
    int    mh[4] = '{0, 0, 0, 0};
    int    cyc = 0, acc_cyc = 0, acc_stall = 0, stall_next = 0;
    int    pops = 0, rel_cnt = 3;
    bit    want_lat = 0, want_rdy = 0, rst_prev = 0, stall_prev = 0;
    logic signed [15:0] prev_data = '0;
    logic  prev_last = 1'b0;

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: y[n] = sat16(floor(sum a_k*y[n-k] / 1024) + 256*e[n]).
    function automatic void model_frame(input logic [80:0] f, input logic last);
        int a[4];
        int e, acc, y;
        for (int k = 0; k < 4; k++) a[k] = int'($signed(f[80-12*k -: 12]));
        if (f[0]) mh = '{0, 0, 0, 0};
        for (int n = 0; n < 8; n++) begin
            e   = int'($signed(f[32-4*n -: 4]));
            acc = a[0]*mh[0] + a[1]*mh[1] + a[2]*mh[2] + a[3]*mh[3];
            y   = (acc >>> 10) + e * 256;
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
            exp_q.push_back('{data: y, last: (n == 7) && last});
            mh[3] = mh[2];
            mh[2] = mh[1];
            mh[1] = mh[0];
            mh[0] = y;
        end
        if (last) mh = '{0, 0, 0, 0};
    endfunction

    function automatic logic [80:0] mkf(input int a1, input int a2, input int a3, input int a4,
                                        input logic [31:0] es, input logic rh);
        return {a1[11:0], a2[11:0], a3[11:0], a4[11:0], es, rh};
    endfunction

    always @(negedge ACLK) begin
        cyc++;
        if (ARESET) begin
            if (rst_prev)
                check_int("reset_outputs", int'({S_TREADY, M_TVALID, M_TLAST, M_TDATA}), 0);
            exp_q.delete();
            mh         = '{0, 0, 0, 0};
            want_lat   = 0;
            want_rdy   = 0;
            rel_cnt    = 0;
            stall_prev = 0;
        end else begin
            if (rel_cnt < 3) rel_cnt++;
            if (rel_cnt == 1) check_int("ready_at_release", int'(S_TREADY), 0);
            if (rel_cnt == 2) check_int("ready_one_cycle_after_release", int'(S_TREADY), 1);
            if (stall_prev && M_TVALID) begin
                check_int("hold_data", int'(M_TDATA), int'(prev_data));
                check_int("hold_last", int'(M_TLAST), int'(prev_last));
            end
            if (M_TVALID) begin
                check_int("ready_low_while_busy", int'(S_TREADY), 0);
                if (want_lat) begin
                    check_int("first_sample_latency", cyc - acc_cyc - 1, 5);
                    want_lat = 0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got %0d, expected no sample", M_TDATA);
                end else begin
                    check_int("sample_data", int'(M_TDATA), exp_q[0].data);
                    check_int("sample_last", int'(M_TLAST), int'(exp_q[0].last));
                    if (M_TREADY) begin
                        void'(exp_q.pop_front());
                        got.push_back(int'(M_TDATA));
                        pops++;
                    end
                end
            end
            if (want_rdy && S_TREADY) begin
                check_int("frame_period", cyc - acc_cyc, 49 + acc_stall);
                want_rdy = 0;
            end
            if (S_TVALID && S_TREADY) begin
                acc_cyc   = cyc;
                acc_stall = stall_next;
                want_lat  = 1;
                want_rdy  = 1;
                model_frame(S_TDATA, S_TLAST);
            end
            stall_prev = M_TVALID && !M_TREADY;
            prev_data  = M_TDATA;
            prev_last  = M_TLAST;
        end
        rst_prev = ARESET;
    end

    task automatic send(input logic [80:0] f, input logic last, input int stall);
        bit ok = 0;
        @(posedge ACLK);
        #1;
        S_TDATA    = f;
        S_TLAST    = last;
        S_TVALID   = 1'b1;
        stall_next = stall;
        for (int i = 0; i < 400; i++) begin
            @(negedge ACLK);
            if (S_TREADY && !ARESET) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no S_TREADY, expected frame accept");
        end
        @(posedge ACLK);
        #1 S_TVALID = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge ACLK);
            if (pops >= n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL sample_timeout: got %0d samples, expected %0d", pops, n);
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge ACLK);
            if (exp_q.size() == 0 && !M_TVALID && S_TREADY) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got %0d pending samples, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, p0;
        int pure_exp[8] = '{256, 512, 768, -256, -2048, 1792, 0, 0};
        int sat_exp[8]  = '{1792, 5374, 12534, 26847, 32767, 32767, 32767, 32767};

        ARESET     = 1'b1;
        M_TREADY   = 1'b1;
        S_TVALID   = 1'b1;
        S_TLAST    = 1'b0;
        S_TDATA    = mkf(0, 0, 0, 0, 32'h123F8700, 1'b1);
        stall_next = 0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;

        // Pure residual frame, held valid across reset.
        base = got.size();
        send(mkf(0, 0, 0, 0, 32'h123F8700, 1'b1), 1'b0, 0);
        wait_idle();
        for (int i = 0; i < 8; i++)
            check_int($sformatf("pure_residual[%0d]", i), got[base+i], pure_exp[i]);

        // Integrator, then continuation without history reset.
        base = got.size();
        send(mkf(1024, 0, 0, 0, 32'h11111111, 1'b1), 1'b0, 0);
        send(mkf(1024, 0, 0, 0, 32'h11111111, 1'b0), 1'b0, 0);
        wait_idle();
        for (int i = 0; i < 16; i++)
            check_int($sformatf("integrator[%0d]", i), got[base+i], 256 * (i + 1));

        // Saturation.
        base = got.size();
        send(mkf(2047, 0, 0, 0, 32'h77777777, 1'b1), 1'b0, 0);
        wait_idle();
        for (int i = 0; i < 8; i++)
            check_int($sformatf("saturation[%0d]", i), got[base+i], sat_exp[i]);

        // All four taps, negative coefficients and residuals, saturated history.
        send(mkf(512, -256, 100, -3, 32'h7F3A1C05, 1'b0), 1'b0, 0);
        send(mkf(-1024, 300, -700, 2047, 32'h89ABCDEF, 1'b1), 1'b0, 0);
        wait_idle();

        // Backpressure on sample 3.
        base = got.size();
        p0   = pops;
        send(mkf(1024, 0, 0, 0, 32'h11111111, 1'b1), 1'b0, 10);
        wait_pops(p0 + 3);
        @(posedge ACLK);
        #1 M_TREADY = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (M_TVALID) break;
        end
        repeat (10) @(posedge ACLK);
        #1 M_TREADY = 1'b1;
        wait_idle();
        check_int("stalled_sample3", got[base+3], 1024);
        check_int("stalled_sample7", got[base+7], 2048);

        // Stream end clears history.
        base = got.size();
        send(mkf(1024, 0, 0, 0, 32'h11111111, 1'b1), 1'b1, 0);
        send(mkf(1024, 0, 0, 0, 32'h10000000, 1'b0), 1'b0, 0);
        wait_idle();
        check_int("tlast_frame_sample7", got[base+7], 2048);
        check_int("after_tlast_sample0", got[base+8], 256);
        check_int("after_tlast_sample7", got[base+15], 256);

        // Reset after sample 2 aborts the frame.
        base = got.size();
        p0   = pops;
        send(mkf(1024, 0, 0, 0, 32'h11111111, 1'b1), 1'b0, 0);
        wait_pops(p0 + 3);
        @(posedge ACLK);
        #1 ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
        repeat (60) @(posedge ACLK);
        check_int("abort_sample_count", got.size() - base, 3);

        base = got.size();
        send(mkf(1024, 0, 0, 0, 32'h10000000, 1'b0), 1'b0, 0);
        wait_idle();
        check_int("after_abort_sample0", got[base], 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
